led_onecold_scanner: RTL and testbench

Parametrised successor to the team's 3-to-8 LED decoder: a SEL_W-to-2^SEL_W one-cold (active-low) decoder with synchronised, debounced switch inputs, registered outputs and an auto-scan mode that walks the active LED at a fixed divided rate. It sits between the board's raw DIP switches and the LED bank. With default parameters, static mode reproduces the existing 3-to-8 behaviour, plus debounce and a clean clocked output.

---
 rtl/led_onecold_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_led_onecold_scanner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_onecold_scanner.sv
// led_onecold_scanner
//
// Turns raw DIP switches into an active-low (one-cold) LED drive. It has two
// modes: a static SEL_W-to-2^SEL_W decode, or an auto-scan that walks the dark
// LED across the bank at a fixed divided rate. Every switch bit passes through
// a 2-flop synchroniser and then a debouncer before it reaches the control
// FSM. The LED outputs are registered.
//
// Parameters
//   SEL_W      select width (1..6); the LED bank is OUT_W = 2**SEL_W wide
//   DEB_CYCLES consecutive differing cycles needed before a debounced bit flips
//   SCAN_DIV   clocks per scan step (>= 2)
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   en_sw    raw enable switch (1 = LEDs driven)
//   mode_sw  raw mode switch (0 = static decode, 1 = scan)
//   sel_sw   raw select switches
//   res_n    LED drive, active-low; all ones when idle, otherwise exactly one zero
//   step     one-cycle pulse, aligned with res_n, whenever the scan index advances
//
// Switch-to-LED latency is DEB_CYCLES+3 edges: 2 synchroniser edges,
// DEB_CYCLES debounce edges, and 1 output-register edge. To meet this, the
// FSM state, the index and the output register all load on the same edge.
// They are computed from the current debounced values, so the output
// register decodes the next state and the next index, not the registered
// ones.
module led_onecold_scanner #(
    parameter int SEL_W      = 3,
    parameter int DEB_CYCLES = 4,
    parameter int SCAN_DIV   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_sw,
    input  logic                    mode_sw,
    input  logic [SEL_W-1:0]        sel_sw,
    output logic [(1 << SEL_W)-1:0] res_n,
    output logic                    step
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int NB    = SEL_W + 2;                 // sel bits + mode + en
    localparam int CW    = $clog2(DEB_CYCLES + 1);
    localparam int DW    = $clog2(SCAN_DIV);

    localparam logic [CW-1:0]    DEB_MAX  = CW'(DEB_CYCLES);
    localparam logic [DW-1:0]    DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [OUT_W-1:0] ONE_HOT0 = OUT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATIC = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser + debouncer, one lane per switch bit
    // Bit layout: [NB-1] = en, [NB-2] = mode, [SEL_W-1:0] = sel
    // ------------------------------------------------------------------
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] deb_q, deb_d;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [CW-1:0] cnt_inc;

    assign raw = {en_sw, mode_sw, sel_sw};

    always_comb begin
        deb_d   = deb_q;
        cnt_inc = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_inc = cnt_q[i] + CW'(1);
                // The flip happens on the edge where the count would reach
                // DEB_CYCLES, so the counter never actually holds DEB_MAX.
                if (cnt_inc == DEB_MAX) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    logic             deb_en;
    logic             deb_mode;
    logic [SEL_W-1:0] deb_sel;

    assign deb_en   = deb_q[NB-1];
    assign deb_mode = deb_q[NB-2];
    assign deb_sel  = deb_q[SEL_W-1:0];

    // ------------------------------------------------------------------
    // Control FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!deb_en) begin
            // A dropped enable beats any simultaneous mode change.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = deb_mode ? ST_SCAN : ST_STATIC;
                ST_STATIC: if (deb_mode)  state_d = ST_SCAN;
                ST_SCAN:   if (!deb_mode) state_d = ST_STATIC;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Index and scan divider, driven by the state being entered this edge.
    logic [SEL_W-1:0] index_q, index_d;
    logic [DW-1:0]    div_q, div_d;
    logic             advance;

    always_comb begin
        index_d = index_q;
        div_d   = '0;
        advance = 1'b0;
        case (state_d)
            ST_STATIC: index_d = deb_sel;
            ST_SCAN: begin
                if (state_q != ST_SCAN) begin
                    // Scan starts from whatever is on the switches.
                    index_d = deb_sel;
                end else if (div_q == DIV_LAST) begin
                    // The index wraps naturally at OUT_W-1 -> 0.
                    index_d = index_q + SEL_W'(1);
                    advance = 1'b1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: index_d = index_q;
        endcase
    end

    logic [OUT_W-1:0] res_n_q, res_n_d;
    logic             step_q, step_d;

    always_comb begin
        res_n_d = '1;
        step_d  = advance;
        if (state_d != ST_IDLE) begin
            res_n_d = ~(ONE_HOT0 << index_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            div_q   <= '0;
            res_n_q <= '1;
            step_q  <= 1'b0;
        end else begin
            index_q <= index_d;
            div_q   <= div_d;
            res_n_q <= res_n_d;
            step_q  <= step_d;
        end
    end

    assign res_n = res_n_q;
    assign step  = step_q;

endmodule

// File: tb/tb_led_onecold_scanner.sv
// Testbench for led_onecold_scanner.
// dut1 uses the default parameters (3-bit select, 8 LEDs, 4-cycle debounce,
// 8-clock scan). dut2 uses SEL_W=2, DEB_CYCLES=1, SCAN_DIV=2.
// Expected {step, res_n} values are queued with the edge count at which they
// must appear. A negedge monitor pops and compares each one when it falls due.
module tb_led_onecold_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_sw = 1'b0, mode_sw = 1'b0;
  logic [2:0] sel_sw = '0;
  logic [7:0] res_n;
  logic       step;
  logic       en2 = 1'b0, mode2 = 1'b0;
  logic [1:0] sel2 = '0;
  logic [3:0] res_n2;
  logic       step2;

  always #5 clk = ~clk;

  led_onecold_scanner dut1 (
    .clk(clk), .rst_n(rst_n), .en_sw(en_sw), .mode_sw(mode_sw),
    .sel_sw(sel_sw), .res_n(res_n), .step(step)
  );

  led_onecold_scanner #(.SEL_W(2), .DEB_CYCLES(1), .SCAN_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en_sw(en2), .mode_sw(mode2),
    .sel_sw(sel2), .res_n(res_n2), .step(step2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // scoreboard: {step, res_n} (dut2 res_n zero-extended), due edge, dut select, tag
  logic [8:0] exp_q[$];
  int         exp_cyc_q[$];
  bit         exp_dut_q[$];
  string      exp_tag_q[$];

  task automatic push_exp(input int c, input bit d, input logic st,
                          input logic [7:0] r, input string tag);
    int pos;
    pos = exp_cyc_q.size();
    for (int i = 0; i < exp_cyc_q.size(); i++) begin
      if (exp_cyc_q[i] > c) begin
        pos = i;
        break;
      end
    end
    exp_cyc_q.insert(pos, c);
    exp_q.insert(pos, {st, r});
    exp_dut_q.insert(pos, d);
    exp_tag_q.insert(pos, tag);
  endtask

  always @(negedge clk) begin
    logic [8:0] obs, e;
    int         c;
    bit         d;
    string      tag;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      c   = exp_cyc_q.pop_front();
      e   = exp_q.pop_front();
      d   = exp_dut_q.pop_front();
      tag = exp_tag_q.pop_front();
      obs = d ? {step2, 4'b0000, res_n2} : {step, res_n};
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s edge=%0d got={step,res_n}=%h expected=%h", tag, c, obs, e);
      end
    end
  end

  function automatic logic [7:0] oc8(input int s);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << s);
  endfunction

  function automatic logic [7:0] oc4(input int s);
    logic [3:0] one;
    one = 4'h1;
    return {4'b0000, ~(one << s)};
  endfunction

  task automatic test_reset();
    int t0;
    rst_n = 1'b0; en_sw = 1'b1; mode_sw = 1'b0; sel_sw = 3'b101;
    en2 = 1'b1; mode2 = 1'b0; sel2 = 2'b10;
    repeat (4) @(negedge clk);
    total++;
    if (res_n !== 8'hFF) begin bad++; $display("FAIL reset_res_n got=%h expected=ff", res_n); end
    total++;
    if (step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b expected=0", step); end
    total++;
    if (res_n2 !== 4'hF) begin bad++; $display("FAIL reset_res_n2 got=%h expected=f", res_n2); end
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    push_exp(t0 + 6, 0, 1'b0, 8'hFF, "release_pre");
    push_exp(t0 + 7, 0, 1'b0, 8'hDF, "release_latency");
    push_exp(t0 + 3, 1, 1'b0, 8'h0F, "release2_pre");
    push_exp(t0 + 4, 1, 1'b0, 8'h0B, "release2_latency");
    repeat (10) @(negedge clk);
  endtask

  task automatic test_static();
    int t0;
    logic [7:0] cur;
    cur = 8'hDF;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      sel_sw = 3'(s);
      t0 = cyc;
      push_exp(t0 + 6, 0, 1'b0, cur, "static_pre");
      push_exp(t0 + 7, 0, 1'b0, oc8(s), "static_decode");
      cur = oc8(s);
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_glitch();
    int t0, len;
    @(negedge clk);
    sel_sw = 3'b000;
    t0 = cyc;
    push_exp(t0 + 7, 0, 1'b0, 8'hFE, "glitch_setup");
    repeat (8) @(negedge clk);
    // select glitch
    @(negedge clk);
    t0 = cyc;
    len = $urandom_range(1, 3);
    sel_sw = 3'b111;
    for (int k = 1; k <= len + 12; k++) push_exp(t0 + k, 0, 1'b0, 8'hFE, "glitch_sel");
    repeat (len) @(negedge clk);
    sel_sw = 3'b000;
    repeat (14) @(negedge clk);
    // enable glitch
    @(negedge clk);
    t0 = cyc;
    len = $urandom_range(1, 3);
    en_sw = 1'b0;
    for (int k = 1; k <= len + 12; k++) push_exp(t0 + k, 0, 1'b0, 8'hFE, "glitch_en");
    repeat (len) @(negedge clk);
    en_sw = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_scan_wrap();
    int t0, e, t1, srand;
    @(negedge clk);
    sel_sw = 3'b110;
    t0 = cyc;
    push_exp(t0 + 7, 0, 1'b0, 8'hBF, "scan_setup");
    repeat (8) @(negedge clk);
    @(negedge clk);
    mode_sw = 1'b1;
    t0 = cyc;
    e = t0 + 7;
    for (int c = t0 + 1; c <= e + 7; c++) push_exp(c, 0, 1'b0, 8'hBF, "scan_hold6");
    push_exp(e + 8, 0, 1'b1, 8'h7F, "scan_step7");
    for (int c = e + 9; c <= e + 15; c++) push_exp(c, 0, 1'b0, 8'h7F, "scan_hold7");
    push_exp(e + 16, 0, 1'b1, 8'hFE, "scan_wrap0");
    for (int c = e + 17; c <= e + 19; c++) push_exp(c, 0, 1'b0, 8'hFE, "scan_hold0");
    repeat (10) @(negedge clk);
    srand = $urandom_range(0, 5);
    sel_sw = 3'(srand);
    repeat (17) @(negedge clk);
    // back to static: shows the debounced select, no step pulse
    @(negedge clk);
    mode_sw = 1'b0;
    t1 = cyc;
    push_exp(t1 + 7, 0, 1'b0, oc8(srand), "scan_to_static");
    push_exp(t1 + 8, 0, 1'b0, oc8(srand), "scan_to_static_hold");
    repeat (10) @(negedge clk);
  endtask

  task automatic test_disable();
    int t0, t2, t3, t4;
    @(negedge clk);
    sel_sw = 3'b011;
    t0 = cyc;
    push_exp(t0 + 7, 0, 1'b0, 8'hF7, "dis_setup");
    repeat (8) @(negedge clk);
    @(negedge clk);
    mode_sw = 1'b1;
    t0 = cyc;
    push_exp(t0 + 7, 0, 1'b0, 8'hF7, "dis_scan_entry");
    repeat (8) @(negedge clk);
    en_sw = 1'b0;
    t2 = cyc;
    push_exp(t2 + 6, 0, 1'b0, 8'hF7, "dis_pre");
    push_exp(t2 + 7, 0, 1'b0, 8'hFF, "dis_blank");
    push_exp(t2 + 8, 0, 1'b0, 8'hFF, "dis_blank_hold");
    repeat (10) @(negedge clk);
    // re-enable with mode still 1: scan restarts from the current select
    @(negedge clk);
    sel_sw = 3'b101;
    en_sw = 1'b1;
    t3 = cyc;
    push_exp(t3 + 6, 0, 1'b0, 8'hFF, "reen_pre");
    push_exp(t3 + 7, 0, 1'b0, 8'hDF, "reen_start");
    push_exp(t3 + 14, 0, 1'b0, 8'hDF, "reen_hold");
    push_exp(t3 + 15, 0, 1'b1, 8'hBF, "reen_step");
    push_exp(t3 + 16, 0, 1'b0, 8'hBF, "reen_step_end");
    repeat (17) @(negedge clk);
    // en fall and mode change together: idle wins
    @(negedge clk);
    en_sw = 1'b0;
    mode_sw = 1'b0;
    t4 = cyc;
    push_exp(t4 + 7, 0, 1'b0, 8'hFF, "simul_idle");
    push_exp(t4 + 8, 0, 1'b0, 8'hFF, "simul_idle_hold");
    repeat (10) @(negedge clk);
  endtask

  task automatic test_sweep();
    int t0, e;
    logic [7:0] cur;
    cur = 8'h0B;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      sel2 = 2'(s);
      t0 = cyc;
      push_exp(t0 + 3, 1, 1'b0, cur, "sweep_pre");
      push_exp(t0 + 4, 1, 1'b0, oc4(s), "sweep_decode");
      cur = oc4(s);
      repeat (5) @(negedge clk);
    end
    @(negedge clk);
    mode2 = 1'b1;
    t0 = cyc;
    e = t0 + 4;
    push_exp(t0 + 3, 1, 1'b0, 8'h07, "sweep_scan_pre");
    push_exp(e, 1, 1'b0, 8'h07, "sweep_scan_entry");
    push_exp(e + 1, 1, 1'b0, 8'h07, "sweep_scan_hold");
    push_exp(e + 2, 1, 1'b1, 8'h0E, "sweep_wrap");
    push_exp(e + 3, 1, 1'b0, 8'h0E, "sweep_hold0");
    push_exp(e + 4, 1, 1'b1, 8'h0D, "sweep_step1");
    push_exp(e + 5, 1, 1'b0, 8'h0D, "sweep_hold1");
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int wait_cycles;
    test_reset();
    test_static();
    test_glitch();
    test_scan_wrap();
    test_disable();
    test_sweep();
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 50) begin
      @(negedge clk);
      wait_cycles++;
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
